// File: rtl/smt_pipe_stage.sv
// Elastic valid/ready pipeline register with a 2-entry skid buffer, per-thread
// selective flush, per-thread occupancy flags and a saturating stall counter.
//
//  state | meaning
//  EMPTY | main invalid, skid invalid; o_Ready=1
//  ONE   | main valid, skid invalid; o_Ready=1
//  FULL  | main valid, skid valid; o_Ready=0, upstream held
module smt_pipe_stage #(
  parameter int PAYLOAD_WIDTH = 160,
  parameter int NUM_THREADS   = 2,
  parameter int TID_WIDTH     = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Valid,
  output logic                     o_Ready,
  input  logic [TID_WIDTH-1:0]     i_TID,
  input  logic [PAYLOAD_WIDTH-1:0] i_Payload,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [TID_WIDTH-1:0]     o_TID,
  output logic [PAYLOAD_WIDTH-1:0] o_Payload,
  input  logic [NUM_THREADS-1:0]   i_Flush_Mask,
  output logic [NUM_THREADS-1:0]   o_Thread_Busy,
  output logic [CNT_WIDTH-1:0]     o_Stall_Cycles,
  input  logic                     i_Clr_Count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                     main_valid_q, main_valid_d;
  logic [TID_WIDTH-1:0]     main_tid_q, main_tid_d;
  logic [PAYLOAD_WIDTH-1:0] main_payload_q, main_payload_d;
  logic                     skid_valid_q, skid_valid_d;
  logic [TID_WIDTH-1:0]     skid_tid_q, skid_tid_d;
  logic [PAYLOAD_WIDTH-1:0] skid_payload_q, skid_payload_d;
  logic [CNT_WIDTH-1:0]     stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // TIDs outside 0..NUM_THREADS-1 are never matched by the mask.
  function automatic logic tid_flushed(input logic [TID_WIDTH-1:0]   tid,
                                       input logic [NUM_THREADS-1:0] mask);
    logic hit;
    hit = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (tid == TID_WIDTH'(t) && mask[t]) hit = 1'b1;
    end
    return hit;
  endfunction

  assign o_Ready        = !skid_valid_q;
  assign o_Valid        = main_valid_q;
  assign o_TID          = main_tid_q;
  assign o_Payload      = main_payload_q;
  assign o_Stall_Cycles = stall_cnt_q;

  assign in_fire  = i_Valid && !skid_valid_q;
  assign out_fire = main_valid_q && i_Ready;

  always_comb begin
    main_valid_d   = main_valid_q;
    main_tid_d     = main_tid_q;
    main_payload_d = main_payload_q;
    skid_valid_d   = skid_valid_q;
    skid_tid_d     = skid_tid_q;
    skid_payload_d = skid_payload_q;

    if (out_fire) begin
      if (skid_valid_q) begin
        main_valid_d   = 1'b1;
        main_tid_d     = skid_tid_q;
        main_payload_d = skid_payload_q;
        skid_valid_d   = 1'b0;
      end else if (in_fire) begin
        main_valid_d   = 1'b1;
        main_tid_d     = i_TID;
        main_payload_d = i_Payload;
      end else begin
        main_valid_d   = 1'b0;
      end
    end else if (in_fire) begin
      if (main_valid_q) begin
        skid_valid_d   = 1'b1;
        skid_tid_d     = i_TID;
        skid_payload_d = i_Payload;
      end else begin
        main_valid_d   = 1'b1;
        main_tid_d     = i_TID;
        main_payload_d = i_Payload;
      end
    end

    // Flush acts on what remains after the transfer; delivered beats are safe.
    if (main_valid_d && tid_flushed(main_tid_d, i_Flush_Mask)) main_valid_d = 1'b0;
    if (skid_valid_d && tid_flushed(skid_tid_d, i_Flush_Mask)) skid_valid_d = 1'b0;

    if (!main_valid_d && skid_valid_d) begin
      main_valid_d   = 1'b1;
      main_tid_d     = skid_tid_d;
      main_payload_d = skid_payload_d;
      skid_valid_d   = 1'b0;
    end

    if (!main_valid_d) begin
      main_tid_d     = '0;
      main_payload_d = '0;
    end
    if (!skid_valid_d) begin
      skid_tid_d     = '0;
      skid_payload_d = '0;
    end
  end

  always_comb begin
    if (i_Clr_Count) begin
      stall_cnt_d = '0;
    end else if (main_valid_q && !i_Ready && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_comb begin
    o_Thread_Busy = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      o_Thread_Busy[t] = (main_valid_q && main_tid_q == TID_WIDTH'(t)) ||
                         (skid_valid_q && skid_tid_q == TID_WIDTH'(t));
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      main_valid_q   <= 1'b0;
      main_tid_q     <= '0;
      main_payload_q <= '0;
      skid_valid_q   <= 1'b0;
      skid_tid_q     <= '0;
      skid_payload_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      main_valid_q   <= main_valid_d;
      main_tid_q     <= main_tid_d;
      main_payload_q <= main_payload_d;
      skid_valid_q   <= skid_valid_d;
      skid_tid_q     <= skid_tid_d;
      skid_payload_q <= skid_payload_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_smt_pipe_stage.sv
// Directed bench for smt_pipe_stage: handshake, skid ordering, flush, counter, reset.
module tb_smt_pipe_stage;

  localparam int PW = 160;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [0:0]    in_tid;
  logic [PW-1:0] in_payload;
  logic          ds_ready;
  logic [1:0]    flush_mask;
  logic          clr_count;

  logic          o_ready, o_valid;
  logic [0:0]    o_tid;
  logic [PW-1:0] o_payload;
  logic [1:0]    o_busy;
  logic [15:0]   o_stall;

  logic          o4_ready, o4_valid;
  logic [0:0]    o4_tid;
  logic [PW-1:0] o4_payload;
  logic [1:0]    o4_busy;
  logic [3:0]    o4_stall;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  smt_pipe_stage dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Valid(in_valid), .o_Ready(o_ready),
    .i_TID(in_tid), .i_Payload(in_payload), .o_Valid(o_valid), .i_Ready(ds_ready),
    .o_TID(o_tid), .o_Payload(o_payload), .i_Flush_Mask(flush_mask),
    .o_Thread_Busy(o_busy), .o_Stall_Cycles(o_stall), .i_Clr_Count(clr_count)
  );

  smt_pipe_stage #(.CNT_WIDTH(4)) dut4 (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Valid(in_valid), .o_Ready(o4_ready),
    .i_TID(in_tid), .i_Payload(in_payload), .o_Valid(o4_valid), .i_Ready(ds_ready),
    .o_TID(o4_tid), .o_Payload(o4_payload), .i_Flush_Mask(flush_mask),
    .o_Thread_Busy(o4_busy), .o_Stall_Cycles(o4_stall), .i_Clr_Count(clr_count)
  );

  assign in_ready = o_ready;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [0:0] t, input logic [PW-1:0] p);
    in_valid   = v;
    in_tid     = t;
    in_payload = p;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    ds_ready   = 1'b1;
    flush_mask = 2'b00;
    clr_count  = 1'b0;
    #12;
    chk("rst_valid", PW'(o_valid), PW'(0));
    chk("rst_ready", PW'(in_ready), PW'(1));
    chk("rst_payload", o_payload, '0);
    chk("rst_busy", PW'(o_busy), PW'(0));
    chk("rst_stall", PW'(o_stall), PW'(0));
    tick();
    rst_n = 1'b1;

    // 1: single beat, 1-cycle latency then drain
    drive(1'b1, 1'b0, PW'(160'hA5));
    tick();
    chk("t1_valid", PW'(o_valid), PW'(1));
    chk("t1_payload", o_payload, PW'(160'hA5));
    chk("t1_tid", PW'(o_tid), PW'(0));
    drive(1'b0, 1'b0, '0);
    tick();
    chk("t1_drain_valid", PW'(o_valid), PW'(0));
    chk("t1_drain_payload", o_payload, '0);

    // 2: fill skid under backpressure, then drain in order
    ds_ready = 1'b0;
    drive(1'b1, 1'b0, PW'(160'h11));
    tick();
    chk("t2_p1_main", o_payload, PW'(160'h11));
    chk("t2_one_ready", PW'(in_ready), PW'(1));
    drive(1'b1, 1'b1, PW'(160'h22));
    tick();
    chk("t2_full_ready", PW'(in_ready), PW'(0));
    drive(1'b1, 1'b0, PW'(160'h33));
    tick();
    chk("t2_held_main", o_payload, PW'(160'h11));
    chk("t2_held_ready", PW'(in_ready), PW'(0));
    chk("t2_busy", PW'(o_busy), PW'(2'b11));
    chk("t2_stall", PW'(o_stall), PW'(2));
    ds_ready = 1'b1;
    tick();
    chk("t2_out2", o_payload, PW'(160'h22));
    chk("t2_out2_tid", PW'(o_tid), PW'(1));
    chk("t2_ready_back", PW'(in_ready), PW'(1));
    tick();
    chk("t2_out3", o_payload, PW'(160'h33));
    chk("t2_out3_valid", PW'(o_valid), PW'(1));
    drive(1'b0, 1'b0, '0);
    tick();
    chk("t2_empty", PW'(o_valid), PW'(0));
    chk("t2_stall_hold", PW'(o_stall), PW'(2));

    // 3: flush thread 0 while FULL with main=T0, skid=T1
    ds_ready = 1'b0;
    drive(1'b1, 1'b0, PW'(160'h44));
    tick();
    drive(1'b1, 1'b1, PW'(160'h55));
    tick();
    drive(1'b0, 1'b0, '0);
    flush_mask = 2'b01;
    tick();
    flush_mask = 2'b00;
    chk("t3_valid", PW'(o_valid), PW'(1));
    chk("t3_tid", PW'(o_tid), PW'(1));
    chk("t3_payload", o_payload, PW'(160'h55));
    chk("t3_ready", PW'(in_ready), PW'(1));
    chk("t3_busy", PW'(o_busy), PW'(2'b10));

    // 4: flush thread 1 on the edge a T1 beat is accepted
    drive(1'b1, 1'b1, PW'(160'h66));
    flush_mask = 2'b10;
    tick();
    drive(1'b0, 1'b0, '0);
    flush_mask = 2'b00;
    chk("t4_valid", PW'(o_valid), PW'(0));
    chk("t4_ready", PW'(in_ready), PW'(1));
    chk("t4_payload", o_payload, '0);
    chk("t4_busy", PW'(o_busy), PW'(0));
    tick();
    chk("t4_nothing", PW'(o_valid), PW'(0));

    // 5: stall counter, clear, saturation on the 4-bit instance
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("t5_clr0", PW'(o_stall), PW'(0));
    drive(1'b1, 1'b0, PW'(160'h77));
    tick();
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_ten", PW'(o_stall), PW'(10));
    chk("t5_ten_w4", PW'(o4_stall), PW'(10));
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("t5_clr", PW'(o_stall), PW'(0));
    chk("t5_clr_w4", PW'(o4_stall), PW'(0));
    for (int i = 0; i < 20; i++) tick();
    chk("t5_twenty", PW'(o_stall), PW'(20));
    chk("t5_sat_w4", PW'(o4_stall), PW'(15));

    // 6: async reset while FULL with a beat being offered
    drive(1'b1, 1'b1, PW'(160'h88));
    tick();
    chk("t6_full", PW'(in_ready), PW'(0));
    drive(1'b1, 1'b0, PW'(160'h99));
    ds_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", PW'(o_valid), PW'(0));
    chk("t6_rst_payload", o_payload, '0);
    chk("t6_rst_tid", PW'(o_tid), PW'(0));
    chk("t6_rst_ready", PW'(in_ready), PW'(1));
    chk("t6_rst_busy", PW'(o_busy), PW'(0));
    chk("t6_rst_stall", PW'(o_stall), PW'(0));
    drive(1'b0, 1'b0, '0);
    tick();
    chk("t6_no_survivor", PW'(o_valid), PW'(0));
    rst_n = 1'b1;
    drive(1'b1, 1'b1, PW'(160'hAB));
    tick();
    chk("t6_new_valid", PW'(o_valid), PW'(1));
    chk("t6_new_payload", o_payload, PW'(160'hAB));
    chk("t6_new_tid", PW'(o_tid), PW'(1));
    drive(1'b0, 1'b0, '0);
    tick();
    chk("t6_new_drain", PW'(o_valid), PW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
